seq_chunked_addsub_nbit: RTL and testbench
==========================================

// Module: seq_chunked_addsub_nbit
// PURPOSE
//  Parametrised multi-cycle add/subtract unit: N-bit operands processed CHUNK bits per cycle, LSB chunk first.
//  Uses a single CHUNK-bit repple_carray_adder_nBit (n=CHUNK) plus a registered carry.
//  Replaces fixed-width parallel adder instances where area matters more than latency.
//  Valid/ready on input and output; sits between operand source and result consumer.
// PARAMETERS
//  N      32  operand/result width; must be a multiple of CHUNK
//  CHUNK  8   bits added per cycle; STEPS = N/CHUNK (1 <= STEPS)
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand set valid
//  in_ready   out  1      unit can accept operands (high only in IDLE)
//  a          in   N      operand A
//  b          in   N      operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: a+b+cin ; 1: a-b-cin
//  out_valid  out  1      result valid, held until taken
//  out_ready  in   1      consumer takes result
//  sum        out  N      result, modulo 2^N
//  cout       out  1      carry-out (sub: 1 = no borrow)
//  ovf        out  1      signed two's-complement overflow
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, out_valid=0, sum=0, cout=0, ovf=0, chunk counter=0, in_ready=0 while rst high.
//  FSM: IDLE -> BUSY on in_valid&in_ready; BUSY -> DONE after chunk STEPS-1; DONE -> IDLE on out_ready.
//  IDLE: in_ready=1. Accept edge latches a, b^{N{sub}}, carry = sub ? ~cin : cin; counter=0.
//  BUSY: each edge adds chunk k of a, latched b, and carry; writes sum[k*CHUNK +: CHUNK]; carry<=chunk cout; k++.
//  Last chunk edge: cout <= MSB-chunk carry-out; ovf <= carry into bit N-1 XOR carry out of bit N-1; state<=DONE.
//  Latency: out_valid rises STEPS edges after the accept edge (STEPS=1 -> next edge).
//  DONE: out_valid=1; sum/cout/ovf stable until out_valid&out_ready edge; then out_valid=0, state=IDLE.
//  in_ready asserts the cycle after hand-off; no same-cycle accept in DONE. Max rate: one op per STEPS+2 cycles.
//  Inputs a/b/cin/sub and in_valid ignored outside IDLE; latched copy used for whole op.
//  sum bits of not-yet-processed chunks are don't-care while BUSY; only DONE values are defined.
//  out_ready while not out_valid: ignored.
//  rst mid-BUSY or mid-DONE: op discarded, no out_valid; outputs return to reset values immediately.
//  Widths: all internal carry/ovf arithmetic exact; no truncation other than sum modulo 2^N.
//  Elaboration check: N % CHUNK != 0 or CHUNK < 1 -> $error.
// TESTING (N=32, CHUNK=8 unless noted)
//  1. a=FFFFFFFF b=00000001 cin=0 sub=0 -> sum=00000000 cout=1 ovf=0; out_valid exactly 4 edges after accept.
//  2. a=00000005 b=00000007 cin=0 sub=1 -> sum=FFFFFFFE cout=0 ovf=0; a=7,b=5 -> sum=2 cout=1.
//  3. a=7FFFFFFF b=00000001 sub=0 -> sum=80000000 cout=0 ovf=1; a=80000000 b=1 sub=1 -> 7FFFFFFF ovf=1.
//  4. out_ready=0 for 10 cycles in DONE -> sum/cout/ovf/out_valid held, in_ready=0, new in_valid not accepted.
//  5. rst pulse after 2 BUSY chunks -> out_valid never rises, in_ready=1 after release, next op (12345678+11111111) -> 23456789.
//  6. N=16 CHUNK=16: a=8000 b=8000 cin=1 -> sum=0001 cout=1 ovf=1, out_valid 1 edge after accept; back-to-back ops, random vs model.

Source files
------------

// File: rtl/seq_chunked_addsub_nbit.sv
// seq_chunked_addsub_nbit
//   Multi-cycle add/subtract unit. An N-bit operand pair is processed CHUNK bits per clock,
//   least-significant chunk first, through one CHUNK-bit adder and a registered carry.
//   Subtraction is performed as a + ~b + ~cin, so cout = 1 means "no borrow".
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand set valid
//   in_ready   unit can accept operands (IDLE only, low while rst is high)
//   a, b       N-bit operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result valid, held until taken
//   out_ready  consumer takes the result
//   sum        N-bit result, modulo 2^N
//   cout       carry-out (sub: 1 = no borrow)
//   ovf        signed two's-complement overflow
module seq_chunked_addsub_nbit #(
  parameter int unsigned N     = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned Steps = (CHUNK >= 1) ? N / CHUNK : 1;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
  localparam int unsigned IdxW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  if (CHUNK < 1) begin : g_chk_chunk
    $error("seq_chunked_addsub_nbit: CHUNK must be at least 1");
  end else if ((N % CHUNK) != 0) begin : g_chk_div
    $error("seq_chunked_addsub_nbit: N must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;     // already inverted for subtraction
  logic            carry_q, carry_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [IdxW-1:0]  base_idx;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   add_res;
  logic             msb_carry_in;

  // Chunk datapath: one CHUNK-bit ripple add per cycle.
  always_comb begin
    base_idx     = IdxW'(32'(cnt_q) * CHUNK);
    a_chunk      = a_q[base_idx +: CHUNK];
    b_chunk      = b_q[base_idx +: CHUNK];
    add_res      = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the chunk MSB recovered from the MSB sum bit.
    msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ add_res[CHUNK-1];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {N{sub}};
          carry_d = sub ? ~cin : cin;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        sum_d[base_idx +: CHUNK] = add_res[CHUNK-1:0];
        carry_d                  = add_res[CHUNK];
        if (cnt_q == LastCnt) begin
          cout_d  = add_res[CHUNK];
          ovf_d   = msb_carry_in ^ add_res[CHUNK];
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_chunked_addsub_nbit.sv
// Bench for seq_chunked_addsub_nbit: a 32/8 instance and a 16/16 instance, scoreboard queues
// filled on accept and drained on result hand-off.
module tb_seq_chunked_addsub_nbit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] sum;
    logic        co;
    logic        ov;
  } res_t;

  res_t q32[$];
  res_t q16[$];

  // 32-bit / 8-bit-chunk instance
  logic        rst32, in_valid32, in_ready32, cin32, sub32, out_valid32, out_ready32;
  logic        cout32, ovf32;
  logic [31:0] a32, b32, sum32;

  // 16-bit / 16-bit-chunk instance
  logic        rst16, in_valid16, in_ready16, cin16, sub16, out_valid16, out_ready16;
  logic        cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  seq_chunked_addsub_nbit #(.N(32), .CHUNK(8)) u_dut32 (
    .clk(clk), .rst(rst32), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .sum(sum32), .cout(cout32), .ovf(ovf32)
  );

  seq_chunked_addsub_nbit #(.N(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst(rst16), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  // Reference: exact integer arithmetic, n-bit wide, signed overflow by sign rule.
  function automatic res_t model(input int unsigned n, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    logic [63:0] mask, aa, bb, full;
    logic        sa, sb, ss;
    res_t        r;
    mask = (64'd1 << n) - 64'd1;
    aa   = {32'h0, a} & mask;
    bb   = {32'h0, b} & mask;
    if (!sub) begin
      full = aa + bb + {63'd0, cin};
      r.co = full[n];
    end else begin
      full = aa - bb - {63'd0, cin};
      r.co = (aa >= bb + {63'd0, cin});
    end
    r.sum = 32'(full & mask);
    sa    = aa[n-1];
    sb    = bb[n-1];
    ss    = full[n-1];
    r.ov  = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    return r;
  endfunction

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub);
    int t = 0;
    @(negedge clk);
    a32 = a; b32 = b; cin32 = cin; sub32 = sub; in_valid32 = 1'b1;
    while (!in_ready32 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (in_ready32 !== 1'b1) begin
      n_fail++;
      $display("FAIL send32 in_ready timeout: got %b required 1", in_ready32);
      in_valid32 = 1'b0;
      return;
    end
    q32.push_back(model(32, a, b, cin, sub));
    @(posedge clk);
    #1 in_valid32 = 1'b0;
  endtask

  task automatic recv32(input string nm);
    res_t exp;
    int   t = 0;
    @(negedge clk);
    while (!out_valid32 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (out_valid32 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s out_valid timeout: got %b required 1", nm, out_valid32);
      return;
    end
    n_checks++;
    if (q32.size() == 0) begin
      n_fail++;
      $display("FAIL %s unexpected result: got sum=%h with empty scoreboard", nm, sum32);
    end else begin
      exp = q32.pop_front();
      if ({sum32, cout32, ovf32} !== {exp.sum, exp.co, exp.ov}) begin
        n_fail++;
        $display("FAIL %s result: got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                 nm, sum32, cout32, ovf32, exp.sum, exp.co, exp.ov);
      end
    end
    out_ready32 = 1'b1;
    @(posedge clk);
    #1 out_ready32 = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub);
    int t = 0;
    @(negedge clk);
    a16 = a; b16 = b; cin16 = cin; sub16 = sub; in_valid16 = 1'b1;
    while (!in_ready16 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (in_ready16 !== 1'b1) begin
      n_fail++;
      $display("FAIL send16 in_ready timeout: got %b required 1", in_ready16);
      in_valid16 = 1'b0;
      return;
    end
    q16.push_back(model(16, {16'h0, a}, {16'h0, b}, cin, sub));
    @(posedge clk);
    #1 in_valid16 = 1'b0;
  endtask

  task automatic recv16(input string nm);
    res_t exp;
    int   t = 0;
    @(negedge clk);
    while (!out_valid16 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (out_valid16 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s out_valid timeout: got %b required 1", nm, out_valid16);
      return;
    end
    n_checks++;
    if (q16.size() == 0) begin
      n_fail++;
      $display("FAIL %s unexpected result: got sum=%h with empty scoreboard", nm, sum16);
    end else begin
      exp = q16.pop_front();
      if ({16'h0, sum16, cout16, ovf16} !== {exp.sum, exp.co, exp.ov}) begin
        n_fail++;
        $display("FAIL %s result: got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                 nm, sum16, cout16, ovf16, exp.sum[15:0], exp.co, exp.ov);
      end
    end
    out_ready16 = 1'b1;
    @(posedge clk);
    #1 out_ready16 = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({in_ready32, out_valid32, sum32, cout32, ovf32} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset32: got rdy=%b vld=%b sum=%h cout=%b ovf=%b required all zero",
               in_ready32, out_valid32, sum32, cout32, ovf32);
    end
    n_checks++;
    if ({in_ready16, out_valid16, sum16, cout16, ovf16} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset16: got rdy=%b vld=%b sum=%h cout=%b ovf=%b required all zero",
               in_ready16, out_valid16, sum16, cout16, ovf16);
    end
    @(negedge clk);
    rst32 = 1'b0;
    rst16 = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready32, in_ready16} !== 2'b11) begin
      n_fail++;
      $display("FAIL idle_ready: got %b%b required 11", in_ready32, in_ready16);
    end
  endtask

  // Carry wrap plus exact 4-edge latency.
  task automatic test_add_wrap();
    send32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid32 !== 1'b0) begin
        n_fail++;
        $display("FAIL latency32 early edge %0d: got out_valid=%b required 0", k, out_valid32);
      end
    end
    @(negedge clk);
    n_checks++;
    if (out_valid32 !== 1'b1) begin
      n_fail++;
      $display("FAIL latency32 edge 4: got out_valid=%b required 1", out_valid32);
    end
    recv32("add_wrap");
  endtask

  task automatic test_sub();
    send32(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    recv32("sub_borrow");
    send32(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);
    recv32("sub_noborrow");
    send32(32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1);
    recv32("sub_borrow_in");
  endtask

  task automatic test_overflow();
    send32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    recv32("ovf_add");
    send32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    recv32("ovf_sub");
    send32(32'h00FF_00FF, 32'h0001_FF01, 1'b1, 1'b0);
    recv32("chunk_carry");
  endtask

  // Result held in DONE under back-pressure; a new request is not accepted there.
  task automatic test_hold();
    res_t exp;
    int   t = 0;
    send32(32'h1234_00FF, 32'h0FED_FF01, 1'b0, 1'b0);
    exp = q32.pop_front();
    @(negedge clk);
    while (!out_valid32 && t < 100) begin
      @(negedge clk);
      t++;
    end
    a32 = 32'hDEAD_BEEF; b32 = 32'h1111_1111; cin32 = 1'b1; sub32 = 1'b1; in_valid32 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if ({out_valid32, in_ready32, sum32, cout32, ovf32} !== {2'b10, exp.sum, exp.co, exp.ov})
      begin
        n_fail++;
        $display("FAIL hold cycle %0d: got vld=%b rdy=%b sum=%h cout=%b ovf=%b required 1 0 %h %b %b",
                 k, out_valid32, in_ready32, sum32, cout32, ovf32, exp.sum, exp.co, exp.ov);
      end
      @(negedge clk);
    end
    out_ready32 = 1'b1;
    @(posedge clk);
    #1 out_ready32 = 1'b0;
    in_valid32 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid32, in_ready32} !== 2'b01) begin
        n_fail++;
        $display("FAIL no_accept_in_done %0d: got vld=%b rdy=%b required 0 1",
                 k, out_valid32, in_ready32);
      end
    end
  endtask

  task automatic test_reset_busy();
    send32(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst32 = 1'b1;
    #1;
    n_checks++;
    if ({out_valid32, in_ready32, sum32, cout32, ovf32} !== 35'd0) begin
      n_fail++;
      $display("FAIL rst_busy outputs: got vld=%b rdy=%b sum=%h cout=%b ovf=%b required all zero",
               out_valid32, in_ready32, sum32, cout32, ovf32);
    end
    q32.delete();
    @(negedge clk);
    rst32 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid32, in_ready32} !== 2'b01) begin
        n_fail++;
        $display("FAIL rst_busy after %0d: got vld=%b rdy=%b required 0 1",
                 k, out_valid32, in_ready32);
      end
    end
    send32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    recv32("after_rst");
  endtask

  task automatic test_random32();
    for (int i = 0; i < 12; i++) begin
      send32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      recv32("random32");
    end
  endtask

  task automatic test_n16();
    send16(16'h8000, 16'h8000, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if (out_valid16 !== 1'b0) begin
      n_fail++;
      $display("FAIL latency16 edge 0: got out_valid=%b required 0", out_valid16);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid16 !== 1'b1) begin
      n_fail++;
      $display("FAIL latency16 edge 1: got out_valid=%b required 1", out_valid16);
    end
    recv16("n16_corner");
    send16(16'h0003, 16'h0004, 1'b0, 1'b1);
    recv16("n16_sub");
  endtask

  task automatic test_back_to_back();
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          send16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
      end
      begin
        for (int j = 0; j < 20; j++) begin
          recv16("b2b16");
        end
      end
    join
    n_checks++;
    if (q16.size() != 0) begin
      n_fail++;
      $display("FAIL b2b16 leftover: got %0d queued results required 0", q16.size());
    end
  endtask

  initial begin
    rst32 = 1'b1; in_valid32 = 1'b0; out_ready32 = 1'b0;
    a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
    rst16 = 1'b1; in_valid16 = 1'b0; out_ready16 = 1'b0;
    a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    test_reset();
    test_add_wrap();
    test_sub();
    test_overflow();
    test_hold();
    test_reset_busy();
    test_random32();
    test_n16();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
